// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode hex scanner that pages between the two 16-bit halves of a captured word.
// Optional build macro LEADZERO_BLANK_EN blanks leading zero digits within the displayed half.
module seven_seg_scanner #(
    parameter int SCAN_DIV = 50000,
    parameter int PAGE_DIV = 500
) (
    input  logic        CLK_IN,
    input  logic        GLOBALRESET,
    input  logic [31:0] value_in,
    input  logic        load_in,
    output logic [6:0]  seg_out,
    output logic [3:0]  digit_out,
    output logic        page_out
);

    localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int PC_W = (PAGE_DIV > 1) ? $clog2(PAGE_DIV) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_DIV - 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PAGE_DIV - 1);

    logic [31:0]     r_cap;
    logic [SC_W-1:0] r_sc;
    logic [1:0]      r_idx;
    logic [PC_W-1:0] r_pc;
    logic            r_pg;

    logic [15:0] w_half;
    logic [3:0]  w_nib;
    logic        w_lz_blank;
    logic        w_slot_start;
    logic        w_sc_wrap;
    logic        w_idx_wrap;
    logic        w_pc_wrap;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'b1000000;
            4'h1: hex_to_seg = 7'b1111001;
            4'h2: hex_to_seg = 7'b0100100;
            4'h3: hex_to_seg = 7'b0110000;
            4'h4: hex_to_seg = 7'b0011001;
            4'h5: hex_to_seg = 7'b0010010;
            4'h6: hex_to_seg = 7'b0000010;
            4'h7: hex_to_seg = 7'b1111000;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0010000;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b0000011;
            4'hC: hex_to_seg = 7'b1000110;
            4'hD: hex_to_seg = 7'b0100001;
            4'hE: hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_half     = r_pg ? r_cap[31:16] : r_cap[15:0];
        w_nib      = w_half[3:0];
        w_lz_blank = 1'b0;
        case (r_idx)
            2'd0: w_nib = w_half[3:0];
            2'd1: w_nib = w_half[7:4];
            2'd2: w_nib = w_half[11:8];
            default: w_nib = w_half[15:12];
        endcase
`ifdef LEADZERO_BLANK_EN
        // A digit is a leading zero when it and every more significant nibble are zero.
        case (r_idx)
            2'd0: w_lz_blank = 1'b0;
            2'd1: w_lz_blank = (w_half[15:4] == 12'h000);
            2'd2: w_lz_blank = (w_half[15:8] == 8'h00);
            default: w_lz_blank = (w_half[15:12] == 4'h0);
        endcase
`else
        w_lz_blank = 1'b0;
`endif
        w_slot_start = (r_sc == '0);
        w_sc_wrap    = (r_sc == SC_LAST);
        w_idx_wrap   = w_sc_wrap && (r_idx == 2'd3);
        w_pc_wrap    = w_idx_wrap && (r_pc == PC_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK_IN or posedge GLOBALRESET) begin
        if (GLOBALRESET) begin
            r_cap     <= '0;
            r_sc      <= '0;
            r_idx     <= '0;
            r_pc      <= '0;
            r_pg      <= 1'b0;
            seg_out   <= 7'h7F;
            digit_out <= 4'hF;
            page_out  <= 1'b0;
        end else begin
            if (load_in) begin
                r_cap <= value_in;
            end
            r_sc <= w_sc_wrap ? '0 : r_sc + 1'b1;
            if (w_sc_wrap) begin
                r_idx <= r_idx + 2'd1;
            end
            if (w_idx_wrap) begin
                r_pc <= w_pc_wrap ? '0 : r_pc + 1'b1;
            end
            if (w_pc_wrap) begin
                r_pg <= ~r_pg;
            end

            // First cycle of each slot is dark so the previous digit's segments never ghost.
            digit_out <= w_slot_start ? 4'hF : ~(4'b0001 << r_idx);
            seg_out   <= (w_slot_start || w_lz_blank) ? 7'h7F : hex_to_seg(w_nib);
            page_out  <= r_pg;
        end
    end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed 4-digit seven-segment driver placed directly downstream of the CPU top level. It captures the 32-bit `$v0` register value tapped out of the register file and scans it onto a 4-digit common-anode display as hexadecimal. It pages automatically between the low and high 16-bit halves. All outputs are registered, and blanking between digit slots prevents ghosting.

## Interface
- `SCAN_DIV`, 50000: clock cycles per digit slot; legal minimum 2.
- `PAGE_DIV`, 500: full 4-digit scans per page before toggling halves; legal minimum 1.
- `CLK_IN` input 1: single clock; all state updates on its rising edge.
- `GLOBALRESET` input 1: asynchronous, active-high reset.
- `value_in` input 32: value to display, normally `$v0` from the register file.
- `load_in` input 1: when high at a rising edge, `value_in` is captured.
- `seg_out` output 7: segments `{g,f,e,d,c,b,a}`, active-low (0 = lit).
- `digit_out` output 4: digit enables, active-low one-hot; bit k is digit k, and digit 0 is the rightmost.
- `page_out` output 1: 0 = showing `value[15:0]`, 1 = showing `value[31:16]`.

## Operation
- State:
  - capture register `cap[31:0]`
  - scan counter `sc` (0..SCAN_DIV-1)
  - digit index `idx[1:0]`
  - page counter `pc` (0..PAGE_DIV-1)
  - page bit `pg`
- Capture: `cap <= value_in` on each edge where `load_in`=1. Otherwise `cap` holds, and changes on `value_in` are ignored.
- Scan counter:
  - `sc` increments every cycle.
  - At `sc`=SCAN_DIV-1, `sc` wraps to 0 and `idx` advances 0→1→2→3→0.
- Paging:
  - Each `idx` wrap 3→0 increments `pc`.
  - When `pc`=PAGE_DIV-1 and `idx` wraps, `pc` returns to 0 and `pg` toggles.
- Nibble select: digit k shows `cap[16*pg+4k+3 : 16*pg+4k]`.
- Hex encoding (active-low `{g..a}`), full table 0–F:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Anti-ghost blank: in the cycle where `sc`=0, the next `digit_out`=4'hF and `seg_out`=7'h7F. The remaining SCAN_DIV-1 cycles of the slot drive `digit_out`=~(1<<`idx`).
- Simultaneous load and page toggle: both take effect on the same edge. The new page displays the newly captured value.
- Reset mid-operation: all state and outputs are forced to reset values immediately (asynchronously). Scanning restarts at digit 0, page 0, on the first edge after deassertion.

## Timing
- Reset values:
  - `digit_out`=4'hF, `seg_out`=7'h7F, `page_out`=0
  - `cap`=0, `sc`=0, `idx`=0, `pc`=0, `pg`=0
- Outputs are registered from current state, so they trail state by 1 cycle.
- `load_in` sampled at edge N: `cap` is valid after N, and `seg_out` reflects it after edge N+1 if the digit is active.
- Digit slot: exactly SCAN_DIV cycles, of which 1 is blank and SCAN_DIV-1 are lit.
- Full scan: 4·SCAN_DIV cycles. Page period: 4·SCAN_DIV·PAGE_DIV cycles.
- `page_out` changes on the same edge that the first (blank) cycle of digit 0 in the new page is registered.

## Configuration
- `LEADZERO_BLANK_EN` defined:
  - Within the displayed half, digits more significant than the highest non-zero nibble are blanked (`seg_out`=7'h7F).
  - Their `digit_out` enable still pulses normally.
  - Digit 0 is always shown, so an all-zero half displays "0".
- `LEADZERO_BLANK_EN` undefined: all four nibbles are always shown, including leading zeros.

## Test plan
All scenarios use SCAN_DIV=4 and PAGE_DIV=2 unless stated.
- Reset behaviour: assert `GLOBALRESET` mid-slot with digit 2 lit → same-cycle `digit_out`=4'hF, `seg_out`=7'h7F, `page_out`=0. After release, the first lit digit is digit 0, appearing from cycle 2.
- Basic scan: load 32'h0000_1234 → digit 0 slot shows `digit_out`=4'b1110 and `seg_out`=7'b0011001 for 3 cycles after 1 blank cycle. Digits 1/2/3 then show 3/2/1 with enables 1101/1011/0111.
- Paging without macro: `cap`=32'h0000_1234 → after 32 cycles `page_out`=1, and all digits show 7'b1000000. After another 32 cycles `page_out`=0.
- Leading-zero blanking with `LEADZERO_BLANK_EN`: `cap`=32'h0000_00A0 → page 0 shows digit 3/2 = 7'h7F, digit 1 = 7'b0001000, digit 0 = 7'b1000000. Page 1 shows only digit 0 lit as 7'b1000000.
- Capture hold: load 32'hDEAD_BEEF, then change `value_in` to 0 with `load_in`=0 → display continues to show F,E,E,b (page 0) and d,A,E,D (page 1).
- Simultaneous load and toggle: pulse `load_in` with 32'h5678_0000 on the page-toggle edge → new page 1 shows 8,7,6,5 on digits 0..3 starting with its first lit cycle.
